// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: command types, frame geometry and
// the FSM state encoding.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int unsigned WORD_W       = 10;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned WR_FRAME_LEN = 13;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_RECV  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

endpackage

// File: rtl/spi_master.sv
// Single-clock SPI master: one SS_n-framed 10-bit MOSI word per command and an
// 8-bit MISO capture for read-data commands.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned GAP             = 2,
    parameter int unsigned RD_SAMPLE_START = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       cmd_err,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    localparam logic [4:0] LAST_WR      = 5'(WR_FRAME_LEN - 1);
    localparam logic [4:0] SAMPLE_FIRST = 5'(RD_SAMPLE_START);
    localparam logic [4:0] SAMPLE_LAST  = 5'(RD_SAMPLE_START + DATA_W - 1);

    logic [1:0]        state;
    logic [4:0]        cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [1:0]        kind;
    logic [WORD_W-1:0] tx_sh;
    logic [DATA_W-2:0] rx_sh;
    logic              addr_pending;

    assign cmd_ready = (state == ST_IDLE) && !rst;

    // Outputs are registered, so each edge computes the values for frame
    // cycle cnt+1 from the current cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            gap_cnt      <= '0;
            kind         <= '0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            addr_pending <= 1'b0;
            SS_n         <= 1'b1;
            MOSI         <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            cmd_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state <= ST_FRAME;
                        cnt   <= '0;
                        kind  <= cmd_type;
                        tx_sh <= {cmd_type, cmd_data};
                        SS_n  <= 1'b0;
                        MOSI  <= cmd_type[1];
                        busy  <= 1'b1;
                    end
                end

                ST_FRAME: begin
                    cnt <= cnt + 5'd1;
                    // F0/F1 repeat word[9]; F2..F11 shift the word out MSB first.
                    if (cnt >= 5'd1 && cnt <= 5'd10) begin
                        MOSI  <= tx_sh[WORD_W-1];
                        tx_sh <= {tx_sh[WORD_W-2:0], 1'b0};
                    end else if (cnt != 5'd0) begin
                        MOSI <= 1'b0;
                    end
                    if (cnt == LAST_WR) begin
                        if (kind == CMD_RD_DATA) begin
                            state <= ST_RECV;
                        end else begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                            SS_n    <= 1'b1;
                            if (kind == CMD_RD_ADDR) begin
                                addr_pending <= 1'b1;
                            end
                        end
                    end
                end

                ST_RECV: begin
                    // Sampling window assumes RD_SAMPLE_START lies beyond F12.
                    cnt  <= cnt + 5'd1;
                    MOSI <= 1'b0;
                    if (cnt >= SAMPLE_FIRST) begin
                        rx_sh <= {rx_sh[DATA_W-3:0], MISO};
                    end
                    if (cnt == SAMPLE_LAST) begin
                        state        <= ST_GAP;
                        gap_cnt      <= '0;
                        SS_n         <= 1'b1;
                        addr_pending <= 1'b0;
                        if (addr_pending) begin
                            rd_valid <= 1'b1;
                            rd_data  <= {rx_sh, MISO};
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed plus randomized bench for spi_master with a behavioural slave/RAM
// model that supplies MISO replies and predicts the frame waveform.
module tb_spi_master;
    import spi_pkg::*;

    localparam int unsigned GAP = 2;
    localparam int unsigned RS  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [7:0] cmd_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       cmd_err;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    spi_master #(.GAP(GAP), .RD_SAMPLE_START(RS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_data  (cmd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .cmd_err   (cmd_err),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int fcyc    = -1;
    int unsigned last_wait;

    // Slave/RAM model and master-visible expectations.
    logic [7:0] mem [256];
    logic [7:0] waddr, raddr;
    bit         pending;
    logic [7:0] exp_rd_data;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at frame cycle %0d: got 0x%0h, expected 0x%0h", tag, fcyc, obs, exp);
        end
    endtask

    function automatic logic exp_mosi(input logic [9:0] w, input int unsigned n);
        if (n < 2) return w[9];
        if (n <= 11) return w[11-n];
        return 1'b0;
    endfunction

    task automatic wait_ready(output bit ok);
        int unsigned waited = 0;
        while (cmd_ready !== 1'b1 && waited < 200) begin
            cycle();
            waited++;
        end
        last_wait = waited;
        ok = (cmd_ready === 1'b1);
        check("accept_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic do_cmd(input logic [1:0] t, input logic [7:0] d, input bit keep);
        logic [9:0]  w;
        logic [7:0]  reply;
        bit          rd, ok;
        int unsigned last;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        wait_ready(ok);
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        w     = {t, d};
        rd    = (t == CMD_RD_DATA);
        last  = rd ? RS + 7 : 12;
        reply = mem[raddr];
        cycle();
        if (!keep) cmd_valid = 1'b0;
        for (int unsigned n = 0; n <= last; n++) begin
            fcyc = int'(n);
            if (rd && n >= RS && n <= RS + 7) MISO = reply[7-(n-RS)];
            else MISO = 1'($urandom);
            check("ss_low",      {31'd0, SS_n},      32'd0);
            check("mosi",        {31'd0, MOSI},      {31'd0, exp_mosi(w, n)});
            check("busy_frame",  {31'd0, busy},      32'd1);
            check("ready_frame", {31'd0, cmd_ready}, 32'd0);
            check("rd_valid_in_frame", {31'd0, rd_valid}, 32'd0);
            check("cmd_err_in_frame",  {31'd0, cmd_err},  32'd0);
            cycle();
        end
        fcyc = int'(last + 1);
        if (rd) begin
            if (pending) exp_rd_data = reply;
            check("rd_valid_end", {31'd0, rd_valid}, {31'd0, pending});
            check("cmd_err_end",  {31'd0, cmd_err},  {31'd0, !pending});
        end else begin
            check("rd_valid_end", {31'd0, rd_valid}, 32'd0);
            check("cmd_err_end",  {31'd0, cmd_err},  32'd0);
        end
        check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd_data});
        for (int unsigned g = 0; g < GAP; g++) begin
            fcyc = int'(last + 1 + g);
            check("ss_gap",    {31'd0, SS_n},      32'd1);
            check("mosi_gap",  {31'd0, MOSI},      32'd0);
            check("busy_gap",  {31'd0, busy},      32'd1);
            check("ready_gap", {31'd0, cmd_ready}, 32'd0);
            cycle();
        end
        fcyc = int'(last + 1 + GAP);
        check("ready_back", {31'd0, cmd_ready}, 32'd1);
        check("busy_idle",  {31'd0, busy},      32'd0);
        check("ss_idle",    {31'd0, SS_n},      32'd1);
        case (t)
            CMD_WR_ADDR: waddr = d;
            CMD_WR_DATA: mem[waddr] = d;
            CMD_RD_ADDR: begin raddr = d; pending = 1'b1; end
            default:     pending = 1'b0;
        endcase
    endtask

    task automatic reset_mid(input logic [1:0] t, input logic [7:0] d, input int unsigned at);
        bit ok;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_data  = d;
        wait_ready(ok);
        if (!ok) begin
            cmd_valid = 1'b0;
            return;
        end
        cycle();
        cmd_valid = 1'b0;
        for (int unsigned n = 0; n < at; n++) cycle();
        fcyc = int'(at);
        check("ss_before_rst", {31'd0, SS_n}, 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        fcyc = int'(at + 1);
        check("rst_ss",       {31'd0, SS_n},      32'd1);
        check("rst_mosi",     {31'd0, MOSI},      32'd0);
        check("rst_busy",     {31'd0, busy},      32'd0);
        check("rst_rd_valid", {31'd0, rd_valid},  32'd0);
        check("rst_cmd_err",  {31'd0, cmd_err},   32'd0);
        check("rst_ready",    {31'd0, cmd_ready}, 32'd1);
        pending     = 1'b0;
        exp_rd_data = 8'h00;
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        waddr = 8'h00;
        raddr = 8'h00;
        pending = 1'b0;
        exp_rd_data = 8'h00;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_type = 2'b00;
        cmd_data = 8'h00;
        MISO = 1'b0;
        repeat (3) cycle();
        check("reset_ss",       {31'd0, SS_n},      32'd1);
        check("reset_mosi",     {31'd0, MOSI},      32'd0);
        check("reset_rd_valid", {31'd0, rd_valid},  32'd0);
        check("reset_rd_data",  {24'd0, rd_data},   32'd0);
        check("reset_cmd_err",  {31'd0, cmd_err},   32'd0);
        check("reset_busy",     {31'd0, busy},      32'd0);
        check("reset_ready",    {31'd0, cmd_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

        // Read-data with no prior read-address
        do_cmd(CMD_RD_DATA, 8'h00, 1'b0);
        do_cmd(CMD_WR_ADDR, 8'h2A, 1'b0);

        mem[8'h15] = 8'hA5;
        do_cmd(CMD_RD_ADDR, 8'h15, 1'b0);
        do_cmd(CMD_RD_DATA, 8'h00, 1'b0);
        do_cmd(CMD_RD_DATA, 8'h00, 1'b0);

        // Back-to-back with cmd_valid held
        do_cmd(CMD_WR_DATA, 8'hFF, 1'b1);
        do_cmd(CMD_WR_DATA, 8'h00, 1'b0);
        check("b2b_no_bubble", last_wait, 32'd0);

        // Loopback through the RAM model
        do_cmd(CMD_WR_ADDR, 8'h10, 1'b0);
        do_cmd(CMD_WR_DATA, 8'h5C, 1'b0);
        do_cmd(CMD_RD_ADDR, 8'h10, 1'b0);
        do_cmd(CMD_RD_DATA, 8'h00, 1'b0);
        check("loopback_rd_data", {24'd0, rd_data}, 32'h5C);

        reset_mid(CMD_WR_DATA, 8'hC3, 7);
        do_cmd(CMD_RD_ADDR, 8'h22, 1'b0);
        reset_mid(CMD_RD_DATA, 8'h00, 18);
        do_cmd(CMD_RD_DATA, 8'h00, 1'b0);

        for (int k = 0; k < 40; k++) begin
            do_cmd(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
